// File: rtl/gcm_tag_verify.sv
// GCM decrypt-side tag verifier: bit-serial GHASH over AAD/ciphertext,
// length block, E(K,J0) whitening and truncated tag compare.
// Ports: clk, reset (sync, active-low), start + hash_subkey/ek_j0/tag_in
// operands, blk_* valid/ready block stream, busy/done/tag_ok/err status.
// Build option: define GCM_GHASH_DIGIT2_EN to retire two multiplier bits
// per cycle (64-cycle multiply); default is one bit per cycle.
module gcm_tag_verify #(
    parameter int TAG_BITS = 128,
    parameter int LEN_W    = 64
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [127:0] hash_subkey,
    input  logic [127:0] ek_j0,
    input  logic [127:0] tag_in,
    input  logic         blk_valid,
    output logic         blk_ready,
    input  logic [127:0] blk_data,
    input  logic         blk_is_aad,
    input  logic [4:0]   blk_bytes,
    input  logic         blk_last,
    output logic         busy,
    output logic         done,
    output logic         tag_ok,
    output logic         err
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_MUL   = 3'd2;
    localparam logic [2:0] S_LEN   = 3'd3;
    localparam logic [2:0] S_FINAL = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;

`ifdef GCM_GHASH_DIGIT2_EN
    localparam logic [6:0] MUL_LAST = 7'd63;
`else
    localparam logic [6:0] MUL_LAST = 7'd127;
`endif

    localparam logic [127:0] R_POLY   = {8'hE1, 120'h0};
    localparam logic [127:0] TAG_MASK = {128{1'b1}} << (128 - TAG_BITS);

    logic [2:0]       state_q, state_d;
    logic [127:0]     h_q, h_d;
    logic [127:0]     ek_q, ek_d;
    logic [127:0]     tag_q, tag_d;
    logic [127:0]     y_q, y_d;
    logic [127:0]     x_q, x_d;
    logic [127:0]     z_q, z_d;
    logic [127:0]     v_q, v_d;
    logic [6:0]       cnt_q, cnt_d;
    logic [LEN_W-1:0] len_a_q, len_a_d;
    logic [LEN_W-1:0] len_c_q, len_c_d;
    logic             last_q, last_d;
    logic             in_len_q, in_len_d;
    logic             seen_c_q, seen_c_d;
    logic             short_a_q, short_a_d;
    logic             short_c_q, short_c_d;
    logic             err_q, err_d;
    logic             tag_ok_q, tag_ok_d;

    logic [4:0]       eff;
    logic [127:0]     bmask;
    logic [LEN_W-1:0] add_bits;
    logic [127:0]     z1, v1, z_nx, v_nx, x_nx;
    logic             blk_short;
`ifdef GCM_GHASH_DIGIT2_EN
    logic [127:0]     z2, v2;
`endif

    // One step of the right-shifting GF(2^128) multiply.
    function automatic logic [255:0] gf_step(
        input logic [127:0] z,
        input logic [127:0] v,
        input logic         b
    );
        logic [127:0] zn;
        logic [127:0] vn;
        zn = b ? (z ^ v) : z;
        vn = v[0] ? ((v >> 1) ^ R_POLY) : (v >> 1);
        return {zn, vn};
    endfunction

    always_comb begin
        state_d   = state_q;
        h_d       = h_q;
        ek_d      = ek_q;
        tag_d     = tag_q;
        y_d       = y_q;
        x_d       = x_q;
        z_d       = z_q;
        v_d       = v_q;
        cnt_d     = cnt_q;
        len_a_d   = len_a_q;
        len_c_d   = len_c_q;
        last_d    = last_q;
        in_len_d  = in_len_q;
        seen_c_d  = seen_c_q;
        short_a_d = short_a_q;
        short_c_d = short_c_q;
        err_d     = err_q;
        tag_ok_d  = tag_ok_q;

        eff = (blk_bytes > 5'd16) ? 5'd16 : blk_bytes;
        bmask = '0;
        for (int i = 0; i < 16; i++) begin
            if (5'(i) < eff) bmask[127 - 8*i -: 8] = 8'hFF;
        end
        add_bits  = LEN_W'({eff, 3'b000});
        blk_short = (eff != 5'd16) && !blk_last;

        {z1, v1} = gf_step(z_q, v_q, x_q[127]);
`ifdef GCM_GHASH_DIGIT2_EN
        {z2, v2} = gf_step(z1, v1, x_q[126]);
        z_nx = z2;
        v_nx = v2;
        x_nx = {x_q[125:0], 2'b00};
`else
        z_nx = z1;
        v_nx = v1;
        x_nx = {x_q[126:0], 1'b0};
`endif

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d   = S_LOAD;
                    h_d       = hash_subkey;
                    ek_d      = ek_j0;
                    tag_d     = tag_in;
                    y_d       = '0;
                    len_a_d   = '0;
                    len_c_d   = '0;
                    last_d    = 1'b0;
                    in_len_d  = 1'b0;
                    seen_c_d  = 1'b0;
                    short_a_d = 1'b0;
                    short_c_d = 1'b0;
                    err_d     = 1'b0;
                    tag_ok_d  = 1'b0;
                end
            end
            S_LOAD: begin
                if (blk_valid) begin
                    // A short block is only legal as the final one of its type.
                    if (blk_is_aad) begin
                        len_a_d   = len_a_q + add_bits;
                        short_a_d = blk_short;
                        if (seen_c_q || short_a_q) err_d = 1'b1;
                    end else begin
                        len_c_d   = len_c_q + add_bits;
                        short_c_d = blk_short;
                        seen_c_d  = 1'b1;
                        if (short_c_q) err_d = 1'b1;
                    end
                    last_d = blk_last;
                    if (eff == 5'd0) begin
                        if (blk_last) state_d = S_LEN;
                    end else begin
                        x_d     = y_q ^ (blk_data & bmask);
                        z_d     = '0;
                        v_d     = h_q;
                        cnt_d   = '0;
                        state_d = S_MUL;
                    end
                end
            end
            S_MUL: begin
                z_d   = z_nx;
                v_d   = v_nx;
                x_d   = x_nx;
                cnt_d = cnt_q + 7'd1;
                if (cnt_q == MUL_LAST) begin
                    y_d = z_nx;
                    if (in_len_q)    state_d = S_FINAL;
                    else if (last_q) state_d = S_LEN;
                    else             state_d = S_LOAD;
                end
            end
            S_LEN: begin
                x_d      = y_q ^ {64'(len_a_q), 64'(len_c_q)};
                z_d      = '0;
                v_d      = h_q;
                cnt_d    = '0;
                in_len_d = 1'b1;
                state_d  = S_MUL;
            end
            S_FINAL: begin
                tag_ok_d = !err_q &&
                           (((y_q ^ ek_q ^ tag_q) & TAG_MASK) == '0);
                state_d  = S_DONE;
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            h_q       <= '0;
            ek_q      <= '0;
            tag_q     <= '0;
            y_q       <= '0;
            x_q       <= '0;
            z_q       <= '0;
            v_q       <= '0;
            cnt_q     <= '0;
            len_a_q   <= '0;
            len_c_q   <= '0;
            last_q    <= 1'b0;
            in_len_q  <= 1'b0;
            seen_c_q  <= 1'b0;
            short_a_q <= 1'b0;
            short_c_q <= 1'b0;
            err_q     <= 1'b0;
            tag_ok_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            h_q       <= h_d;
            ek_q      <= ek_d;
            tag_q     <= tag_d;
            y_q       <= y_d;
            x_q       <= x_d;
            z_q       <= z_d;
            v_q       <= v_d;
            cnt_q     <= cnt_d;
            len_a_q   <= len_a_d;
            len_c_q   <= len_c_d;
            last_q    <= last_d;
            in_len_q  <= in_len_d;
            seen_c_q  <= seen_c_d;
            short_a_q <= short_a_d;
            short_c_q <= short_c_d;
            err_q     <= err_d;
            tag_ok_q  <= tag_ok_d;
        end
    end

    assign blk_ready = (state_q == S_LOAD);
    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_DONE);
    assign tag_ok    = tag_ok_q;
    assign err       = err_q;

endmodule

// File: tb/tb_gcm_tag_verify.sv
// Self-checking bench for gcm_tag_verify: known GCM vectors, sequence
// errors, mid-run reset, held-valid back-pressure and random messages.
module tb_gcm_tag_verify;

`ifdef GCM_GHASH_DIGIT2_EN
    localparam int MULC = 64;
`else
    localparam int MULC = 128;
`endif

    localparam logic [127:0] KH  = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;
    localparam logic [127:0] KEK = 128'h58e2fccefa7e3061367f1d57a4e7455a;
    localparam logic [127:0] KC  = 128'h0388dace60b6a392f328c2b971b2fe78;
    localparam logic [127:0] KT  = 128'hab6e47d42cec13bdf53a67b21257bddf;

    logic         clk;
    logic         reset;
    logic         start;
    logic [127:0] hash_subkey;
    logic [127:0] ek_j0;
    logic [127:0] tag_in;
    logic         blk_valid;
    logic [127:0] blk_data;
    logic         blk_is_aad;
    logic [4:0]   blk_bytes;
    logic         blk_last;
    logic         blk_ready, busy, done, tag_ok, err;
    logic         blk_ready_96, busy_96, done_96, tag_ok_96, err_96;

    int n_tests = 0;
    int n_fail  = 0;

    gcm_tag_verify #(.TAG_BITS(128), .LEN_W(64)) dut (
        .clk(clk), .reset(reset), .start(start),
        .hash_subkey(hash_subkey), .ek_j0(ek_j0), .tag_in(tag_in),
        .blk_valid(blk_valid), .blk_ready(blk_ready),
        .blk_data(blk_data), .blk_is_aad(blk_is_aad),
        .blk_bytes(blk_bytes), .blk_last(blk_last),
        .busy(busy), .done(done), .tag_ok(tag_ok), .err(err)
    );

    gcm_tag_verify #(.TAG_BITS(96), .LEN_W(64)) dut96 (
        .clk(clk), .reset(reset), .start(start),
        .hash_subkey(hash_subkey), .ek_j0(ek_j0), .tag_in(tag_in),
        .blk_valid(blk_valid), .blk_ready(blk_ready_96),
        .blk_data(blk_data), .blk_is_aad(blk_is_aad),
        .blk_bytes(blk_bytes), .blk_last(blk_last),
        .busy(busy_96), .done(done_96), .tag_ok(tag_ok_96), .err(err_96)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Negedge monitor: cycle counter, done pulses, handshake cycles.
    int cyc = 0;
    int done_cnt = 0;
    int done_cyc = 0;
    int hs_q[$];
    always @(negedge clk) begin
        cyc++;
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (blk_valid && blk_ready) hs_q.push_back(cyc);
    end

    // Message under test.
    logic [127:0] m_data[$];
    bit           m_aad[$];
    int           m_bytes[$];
    bit           m_last[$];

    task automatic clear_msg();
        m_data.delete(); m_aad.delete();
        m_bytes.delete(); m_last.delete();
    endtask

    task automatic add_blk(input logic [127:0] d, input bit a,
                           input int nb, input bit l);
        m_data.push_back(d); m_aad.push_back(a);
        m_bytes.push_back(nb); m_last.push_back(l);
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Polynomial-basis multiply: bit 127 of the operand is x^0.
    function automatic logic [127:0] gf_mul(input logic [127:0] a,
                                            input logic [127:0] b);
        logic [255:0] p;
        logic [255:0] rb;
        logic [127:0] r;
        p = '0;
        rb = '0;
        r = '0;
        for (int i = 0; i < 128; i++) rb[i] = b[127-i];
        for (int i = 0; i < 128; i++) if (a[127-i]) p = p ^ (rb << i);
        for (int k = 254; k >= 128; k--) begin
            if (p[k]) begin
                p[k] = 1'b0;
                p[k-121] = ~p[k-121];
                p[k-126] = ~p[k-126];
                p[k-127] = ~p[k-127];
                p[k-128] = ~p[k-128];
            end
        end
        for (int i = 0; i < 128; i++) r[127-i] = p[i];
        return r;
    endfunction

    function automatic logic [127:0] model_tag(input logic [127:0] h,
                                               input logic [127:0] ek);
        logic [127:0] y;
        logic [127:0] m;
        logic [63:0]  la, lc;
        int           eff;
        y = '0; la = '0; lc = '0;
        foreach (m_data[i]) begin
            eff = (m_bytes[i] > 16) ? 16 : m_bytes[i];
            if (m_aad[i]) la = la + 64'(8*eff);
            else          lc = lc + 64'(8*eff);
            if (eff > 0) begin
                m = ~128'b0 << (8*(16-eff));
                y = gf_mul(y ^ (m_data[i] & m), h);
            end
        end
        y = gf_mul(y ^ {la, lc}, h);
        return y ^ ek;
    endfunction

    function automatic bit model_err();
        bit e;
        e = 1'b0;
        foreach (m_data[i]) begin
            for (int j = i + 1; j < m_data.size(); j++) begin
                if (!m_aad[i] && m_aad[j]) e = 1'b1;
                if (m_aad[i] == m_aad[j] && m_bytes[i] < 16 && !m_last[i])
                    e = 1'b1;
            end
        end
        return e;
    endfunction

    // Drives one whole message; reports done count, last-accept-to-done
    // latency, accept count and smallest gap between accepts.
    task automatic run_msg(input logic [127:0] h, input logic [127:0] ek,
                           input logic [127:0] tg, input bit hold,
                           output int n_done, output int lat,
                           output int n_hs, output int min_gap);
        int d0, h0, guard, n;
        d0 = done_cnt;
        h0 = hs_q.size();
        @(posedge clk); #1;
        hash_subkey = h; ek_j0 = ek; tag_in = tg; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        foreach (m_data[b]) begin
            if (!hold) begin
                blk_valid = 1'b0;
                n = $urandom_range(0, 2);
                repeat (n) begin @(posedge clk); #1; end
            end
            blk_valid  = 1'b1;
            blk_data   = m_data[b];
            blk_is_aad = m_aad[b];
            blk_bytes  = 5'(m_bytes[b]);
            blk_last   = m_last[b];
            guard = 0;
            forever begin
                @(negedge clk);
                if (blk_ready) begin
                    @(posedge clk); #1;
                    break;
                end
                guard++;
                if (guard > 2000) break;
            end
        end
        if (hold) begin
            blk_data = rnd128();
            blk_is_aad = 1'b0;
            blk_bytes = 5'd16;
            blk_last = 1'b1;
        end else begin
            blk_valid = 1'b0;
        end
        guard = 0;
        while (done_cnt == d0 && guard < 5000) begin
            @(negedge clk);
            guard++;
        end
        repeat (4) @(negedge clk);
        blk_valid = 1'b0;
        n_done = done_cnt - d0;
        n_hs = hs_q.size() - h0;
        lat = (n_hs > 0) ? (done_cyc - hs_q[$]) : -1;
        min_gap = 1 << 30;
        for (int i = h0 + 1; i < hs_q.size(); i++)
            if (hs_q[i] - hs_q[i-1] < min_gap) min_gap = hs_q[i] - hs_q[i-1];
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_tests++;
        if (blk_ready !== 1'b0) begin
            n_fail++; $display("FAIL reset_ready got %b want 0", blk_ready);
        end
        n_tests++;
        if (busy !== 1'b0) begin
            n_fail++; $display("FAIL reset_busy got %b want 0", busy);
        end
        n_tests++;
        if (done !== 1'b0) begin
            n_fail++; $display("FAIL reset_done got %b want 0", done);
        end
        n_tests++;
        if (tag_ok !== 1'b0) begin
            n_fail++; $display("FAIL reset_tag_ok got %b want 0", tag_ok);
        end
        n_tests++;
        if (err !== 1'b0) begin
            n_fail++; $display("FAIL reset_err got %b want 0", err);
        end
        @(posedge clk); #1;
        reset = 1'b1;
    endtask

    task automatic test_empty();
        int nd, lat, nh, mg;
        clear_msg();
        add_blk(rnd128(), 1'b0, 0, 1'b1);
        run_msg(KH, KEK, KEK, 1'b0, nd, lat, nh, mg);
        n_tests++;
        if (nd !== 1) begin
            n_fail++; $display("FAIL empty_done got %0d want 1", nd);
        end
        n_tests++;
        if (tag_ok !== 1'b1) begin
            n_fail++; $display("FAIL empty_tag_ok got %b want 1", tag_ok);
        end
        n_tests++;
        if (err !== 1'b0) begin
            n_fail++; $display("FAIL empty_err got %b want 0", err);
        end
        n_tests++;
        if (lat !== MULC + 3) begin
            n_fail++; $display("FAIL empty_latency got %0d want %0d",
                               lat, MULC + 3);
        end
    endtask

    task automatic test_one_block();
        int nd, lat, nh, mg;
        clear_msg();
        add_blk(KC, 1'b0, 16, 1'b1);
        run_msg(KH, KEK, KT, 1'b0, nd, lat, nh, mg);
        n_tests++;
        if (tag_ok !== 1'b1 || tag_ok_96 !== 1'b1) begin
            n_fail++; $display("FAIL one_block_tag_ok got %b/%b want 1/1",
                               tag_ok, tag_ok_96);
        end
        n_tests++;
        if (err !== 1'b0 || nd !== 1) begin
            n_fail++; $display("FAIL one_block_status err %b done %0d want 0 1",
                               err, nd);
        end
        n_tests++;
        if (lat !== 2*MULC + 3) begin
            n_fail++; $display("FAIL one_block_latency got %0d want %0d",
                               lat, 2*MULC + 3);
        end
    endtask

    task automatic test_tag_trunc();
        int nd, lat, nh, mg;
        logic [127:0] tg;
        int flips[3] = '{0, 31, 32};
        bit want96[3] = '{1'b1, 1'b1, 1'b0};
        clear_msg();
        add_blk(KC, 1'b0, 16, 1'b1);
        foreach (flips[k]) begin
            tg = KT ^ (128'd1 << flips[k]);
            run_msg(KH, KEK, tg, 1'b0, nd, lat, nh, mg);
            n_tests++;
            if (tag_ok !== 1'b0) begin
                n_fail++; $display("FAIL trunc128_bit%0d got %b want 0",
                                   flips[k], tag_ok);
            end
            n_tests++;
            if (tag_ok_96 !== want96[k]) begin
                n_fail++; $display("FAIL trunc96_bit%0d got %b want %b",
                                   flips[k], tag_ok_96, want96[k]);
            end
        end
    endtask

    task automatic test_seq_err();
        int nd, lat, nh, mg;
        logic [127:0] h, ek, t;
        for (int c = 0; c < 2; c++) begin
            h = rnd128(); ek = rnd128();
            clear_msg();
            if (c == 0) begin
                add_blk(rnd128(), 1'b0, 16, 1'b0);
                add_blk(rnd128(), 1'b1, 16, 1'b1);
            end else begin
                add_blk(rnd128(), 1'b0, 8, 1'b0);
                add_blk(rnd128(), 1'b0, 16, 1'b1);
            end
            t = model_tag(h, ek);
            run_msg(h, ek, t, 1'b0, nd, lat, nh, mg);
            n_tests++;
            if (err !== model_err()) begin
                n_fail++; $display("FAIL seq_err%0d_err got %b want %b",
                                   c, err, model_err());
            end
            n_tests++;
            if (tag_ok !== 1'b0 || tag_ok_96 !== 1'b0) begin
                n_fail++; $display("FAIL seq_err%0d_tag_ok got %b/%b want 0/0",
                                   c, tag_ok, tag_ok_96);
            end
            n_tests++;
            if (nd !== 1) begin
                n_fail++; $display("FAIL seq_err%0d_done got %0d want 1", c, nd);
            end
        end
    endtask

    task automatic test_reset_mid();
        int nd, lat, nh, mg, d0, guard;
        @(posedge clk); #1;
        hash_subkey = KH; ek_j0 = KEK; tag_in = KT; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        blk_valid = 1'b1; blk_data = KC; blk_is_aad = 1'b0;
        blk_bytes = 5'd16; blk_last = 1'b1;
        guard = 0;
        forever begin
            @(negedge clk);
            if (blk_ready || guard > 100) break;
            guard++;
        end
        @(posedge clk); #1;
        blk_valid = 1'b0;
        d0 = done_cnt;
        repeat (49) @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk); #1;
        n_tests++;
        if ({busy, blk_ready, done, tag_ok, err} !== 5'b0) begin
            n_fail++; $display("FAIL mid_reset_outputs got %b want 00000",
                               {busy, blk_ready, done, tag_ok, err});
        end
        reset = 1'b1;
        repeat (300) @(negedge clk);
        n_tests++;
        if (done_cnt !== d0 || busy !== 1'b0) begin
            n_fail++; $display("FAIL mid_reset_no_done got %0d busy %b want 0 0",
                               done_cnt - d0, busy);
        end
        clear_msg();
        add_blk(KC, 1'b0, 16, 1'b1);
        run_msg(KH, KEK, KT, 1'b0, nd, lat, nh, mg);
        n_tests++;
        if (tag_ok !== 1'b1 || nd !== 1) begin
            n_fail++; $display("FAIL mid_reset_rerun tag_ok %b done %0d want 1 1",
                               tag_ok, nd);
        end
    endtask

    task automatic test_back_to_back();
        int nd, lat, nh, mg;
        logic [127:0] h, ek, t;
        h = rnd128(); ek = rnd128();
        clear_msg();
        add_blk(rnd128(), 1'b0, 16, 1'b0);
        add_blk(rnd128(), 1'b0, 16, 1'b0);
        add_blk(rnd128(), 1'b0, 5, 1'b1);
        t = model_tag(h, ek);
        run_msg(h, ek, t, 1'b1, nd, lat, nh, mg);
        n_tests++;
        if (nh !== 3) begin
            n_fail++; $display("FAIL b2b_accepts got %0d want 3", nh);
        end
        n_tests++;
        if (mg !== MULC + 1) begin
            n_fail++; $display("FAIL b2b_gap got %0d want %0d", mg, MULC + 1);
        end
        n_tests++;
        if (tag_ok !== 1'b1 || nd !== 1) begin
            n_fail++; $display("FAIL b2b_tag tag_ok %b done %0d want 1 1",
                               tag_ok, nd);
        end
    endtask

    task automatic test_random();
        int nd, lat, nh, mg, na, nc;
        logic [127:0] h, ek, t, tg;
        bit w128, w96;
        for (int it = 0; it < 8; it++) begin
            h = rnd128(); ek = rnd128();
            na = $urandom_range(0, 2);
            nc = $urandom_range(1, 3);
            clear_msg();
            for (int i = 0; i < na; i++)
                add_blk(rnd128(), 1'b1,
                        (i == na - 1) ? $urandom_range(1, 16) : 16, 1'b0);
            for (int i = 0; i < nc; i++)
                add_blk(rnd128(), 1'b0,
                        (i == nc - 1) ? $urandom_range(1, 20) : 16,
                        i == nc - 1);
            t = model_tag(h, ek);
            tg = t;
            if ($urandom_range(0, 1) == 1)
                tg = t ^ (128'd1 << $urandom_range(0, 127));
            w128 = (tg == t);
            w96 = (tg[127:32] == t[127:32]);
            run_msg(h, ek, tg, 1'b0, nd, lat, nh, mg);
            n_tests++;
            if (tag_ok !== w128) begin
                n_fail++; $display("FAIL rand%0d_tag_ok got %b want %b",
                                   it, tag_ok, w128);
            end
            n_tests++;
            if (tag_ok_96 !== w96) begin
                n_fail++; $display("FAIL rand%0d_tag_ok96 got %b want %b",
                                   it, tag_ok_96, w96);
            end
            n_tests++;
            if (err !== model_err() || nd !== 1) begin
                n_fail++; $display("FAIL rand%0d_status err %b done %0d want %b 1",
                                   it, err, nd, model_err());
            end
        end
    endtask

    initial begin
        reset = 1'b0; start = 1'b0;
        hash_subkey = '0; ek_j0 = '0; tag_in = '0;
        blk_valid = 1'b0; blk_data = '0; blk_is_aad = 1'b0;
        blk_bytes = '0; blk_last = 1'b0;
        test_reset();
        test_empty();
        test_one_block();
        test_tag_trunc();
        test_seq_err();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/gcm_tag_verify.md
Name: gcm_tag_verify

Overview:
- Decrypt-side authentication end of the GCM datapath. Consumes AAD and ciphertext blocks in order and runs GHASH with a bit-serial GF(2^128) multiplier.
- Appends the GCM length block, XORs the result with E(K,J0) and compares it against the received tag.
- Reports pass/fail. It is the verifier counterpart to the encrypt-side single-cycle GHASH/tag generation.

Parameters:
- TAG_BITS, 128: compared tag length in bits, legal 96..128; only the top TAG_BITS bits of the tag are compared.
- LEN_W, 64: width of each bit-length counter in the length block; fixed by GCM, exposed for test reduction only.

Ports:
- clk  input  1  clock
- reset  input  1  synchronous active-low reset
- start  input  1  pulse in IDLE; latches hash_subkey, ek_j0, tag_in
- hash_subkey  input  128  H = E(K,0^128)
- ek_j0  input  128  E(K,J0)
- tag_in  input  128  received tag, MSB-aligned
- blk_valid  input  1  block offered
- blk_ready  output  1  block accepted when blk_valid & blk_ready
- blk_data  input  128  block, GCM bit order (bit 127 = first bit)
- blk_is_aad  input  1  1 = AAD block, 0 = ciphertext block
- blk_bytes  input  5  valid bytes 0..16, MSB-aligned
- blk_last  input  1  final block of the message
- busy  output  1  not IDLE
- done  output  1  one-cycle pulse, result valid
- tag_ok  output  1  comparison result, held until next start
- err  output  1  sequence error, held until next start

Behaviour:
- Reset: synchronous, active-low, sampled on rising clk.
  - On reset: state=IDLE; blk_ready, busy, done, tag_ok, err = 0; accumulator Y, length counters and latched operands = 0.
  - Reset mid-operation aborts immediately; no done pulse is produced.
- States: IDLE, LOAD, MUL, LEN, FINAL, DONE.
- IDLE:
  - start moves to LOAD, latches operands, and clears Y, len_a, len_c, tag_ok and err.
  - start outside IDLE is ignored.
- LOAD:
  - blk_ready=1 only in LOAD.
  - On handshake, bytes at index >= blk_bytes are masked to zero.
  - len_a or len_c (selected by blk_is_aad) gains 8*blk_bytes.
  - If blk_bytes=0, the block is not hashed: move to LEN when blk_last, else stay in LOAD.
  - Otherwise X = Y ^ masked block and move to MUL.
- MUL:
  - Z=0, V=H. For i=0..127:
    - if X[127-i] then Z ^= V;
    - V = V[0] ? (V>>1) ^ {8'hE1,120'h0} : V>>1.
  - Exactly 128 cycles; then Y=Z.
  - Next state: LEN if the last block was flagged, LEN-done goes to FINAL, otherwise LOAD.
- LEN: X = Y ^ {len_a, len_c} (LEN_W bits each, bits not bytes); go to MUL.
- FINAL: T = Y ^ ek_j0; tag_ok = (T[127:128-TAG_BITS] == tag_in[127:128-TAG_BITS]); go to DONE.
- DONE: done=1 for exactly one cycle; go to IDLE.
- Sequence error: an AAD block accepted after any ciphertext block, or blk_bytes<16 on a non-last block of the same type followed by more of that type.
  - Effect: err=1, tag_ok forced 0, processing continues to DONE.
- blk_bytes>16: treated as 16.
- Length counters wrap modulo 2^LEN_W.
- Latency: each hashed block takes 1 accept cycle + 128 cycles. Last block to done = 128 (LEN) + 1 (LEN) + 1 (FINAL) + 1 cycles.
- Empty message (single blk_bytes=0, blk_last block) hashes only the length block.

Optional Feature:
- Macro: GCM_GHASH_DIGIT2_EN.
- Defined: MUL processes two bits per cycle (bits X[127-2k] then X[126-2k]), so 64 cycles per multiply. Results are identical; latency constants halve accordingly.
- Undefined: 1 bit/cycle, 128 cycles per multiply.

Test Plan:
- Empty message: H=66e94bd4ef8a2c3b884cfa59ca342b2e, ek_j0=58e2fccefa7e3061367f1d57a4e7455a, tag_in=ek_j0, one blk_bytes=0 last block -> done after 131 cycles, tag_ok=1, err=0.
- One ciphertext block: C=0388dace60b6a392f328c2b971b2fe78, blk_bytes=16, last, same H and ek_j0, tag_in=ab6e47d42cec13bdf53a67b21257bddf -> tag_ok=1.
- Same as the one-block case with tag_in bit 0 flipped, TAG_BITS=128 -> tag_ok=0. With TAG_BITS=96 -> tag_ok=1.
- AAD block sent after a ciphertext block -> err=1, tag_ok=0, done still pulses once.
- reset low during MUL cycle 50 -> next cycle IDLE, all outputs 0, no done. A fresh start then gives the correct one-block result.
- blk_valid held high during MUL -> blk_ready=0, no extra accept, len_c increments exactly once per handshake.
